// File: rtl/fpu_exception_unit_if.sv
// rtl/fpu_exception_unit_if.sv - request/result/status bundle for fpu_exception_unit
interface fpu_exception_unit_if #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int CNT_W = 8
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic             IN_VALID;
   logic             IN_READY;
   logic [1:0]       FP_OPERATION;
   logic [W-1:0]     OP_A;
   logic [W-1:0]     OP_B;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic             OP_IS_EXCEPTION;
   logic [2:0]       FP_EXCE;
   logic [3:0]       STICKY_FLAGS;
   logic             STICKY_CLR;
   logic [CNT_W-1:0] EXCE_COUNT;

   modport master (
      output IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, STICKY_CLR,
      input  IN_READY, OUT_VALID, OP_IS_EXCEPTION, FP_EXCE, STICKY_FLAGS, EXCE_COUNT
   );

   modport slave (
      input  IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, STICKY_CLR,
      output IN_READY, OUT_VALID, OP_IS_EXCEPTION, FP_EXCE, STICKY_FLAGS, EXCE_COUNT
   );
endinterface

// File: rtl/fpu_exception_unit.sv
// rtl/fpu_exception_unit.sv - registered FP operand exception classifier with sticky status
module fpu_exception_unit #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int CNT_W = 8
) (
   input logic                 CLK,
   input logic                 RST,
   fpu_exception_unit_if.slave io
);
   localparam int W = 1 + EXP_W + MAN_W;

   localparam logic [2:0] EXC_NONE = 3'b000;
   localparam logic [2:0] EXC_QNAN = 3'b001;
   localparam logic [2:0] EXC_INV  = 3'b010;
   localparam logic [2:0] EXC_DBZ  = 3'b011;
   localparam logic [2:0] EXC_SNAN = 3'b100;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef struct packed {
      logic sign;
      logic snan;
      logic qnan;
      logic inf;
      logic zero;
   } cls_t;

   function automatic cls_t classify(input logic [W-1:0] v);
      cls_t              c;
      logic [EXP_W-1:0]  e;
      logic [MAN_W-1:0]  m;
      e      = v[W-2:MAN_W];
      m      = v[MAN_W-1:0];
      c.sign = v[W-1];
      c.snan = (&e) && (|m) && !m[MAN_W-1];
      c.qnan = (&e) && m[MAN_W-1];
      c.inf  = (&e) && !(|m);
      c.zero = !(|e) && !(|m);
      return c;
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [2:0]       exce_q, exce_d;
   logic             is_exc_q, is_exc_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] count_q, count_d;

   cls_t             ca, cb;
   logic             in_ready;
   logic             accept;
   logic             invalid;
   logic             div_zero;
   logic [2:0]       code;
   logic [3:0]       ev_flags;
   logic [3:0]       flags_base;
   logic [CNT_W-1:0] count_base;

   assign in_ready = !out_valid_q || io.OUT_READY;
   assign accept   = io.IN_VALID && in_ready;

   always_comb begin
      ca       = classify(io.OP_A);
      cb       = classify(io.OP_B);
      invalid  = 1'b0;
      div_zero = 1'b0;
      case (io.FP_OPERATION)
         OP_ADD: invalid = ca.inf && cb.inf && (ca.sign != cb.sign);
         OP_SUB: invalid = ca.inf && cb.inf && (ca.sign == cb.sign);
         OP_MUL: invalid = (ca.zero && cb.inf) || (ca.inf && cb.zero);
         OP_DIV: begin
            invalid  = (ca.zero && cb.zero) || (ca.inf && cb.inf);
            // inf/0 is an exact infinity, not a divide-by-zero
            div_zero = cb.zero && !ca.zero && !ca.inf;
         end
         default: ;
      endcase

      code     = EXC_NONE;
      ev_flags = 4'b0000;
      if (ca.snan || cb.snan) begin
         code     = EXC_SNAN;
         ev_flags = 4'b1001;
      end else if (ca.qnan || cb.qnan) begin
         code     = EXC_QNAN;
         ev_flags = 4'b0100;
      end else if (invalid) begin
         code     = EXC_INV;
         ev_flags = 4'b0001;
      end else if (div_zero) begin
         code     = EXC_DBZ;
         ev_flags = 4'b0010;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      exce_d      = exce_q;
      is_exc_d    = is_exc_q;
      if (accept) begin
         out_valid_d = 1'b1;
         exce_d      = code;
         is_exc_d    = (code != EXC_NONE);
      end else if (out_valid_q && io.OUT_READY) begin
         out_valid_d = 1'b0;
      end

      // clear takes effect before a coincident event is recorded
      flags_base = io.STICKY_CLR ? 4'b0000 : flags_q;
      count_base = io.STICKY_CLR ? '0 : count_q;
      flags_d    = flags_base;
      count_d    = count_base;
      if (accept) begin
         flags_d = flags_base | ev_flags;
         if ((code != EXC_NONE) && (count_base != {CNT_W{1'b1}}))
            count_d = count_base + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         exce_q      <= EXC_NONE;
         is_exc_q    <= 1'b0;
         flags_q     <= 4'b0000;
         count_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         exce_q      <= exce_d;
         is_exc_q    <= is_exc_d;
         flags_q     <= flags_d;
         count_q     <= count_d;
      end
   end

   assign io.IN_READY        = in_ready;
   assign io.OUT_VALID       = out_valid_q;
   assign io.FP_EXCE         = exce_q;
   assign io.OP_IS_EXCEPTION = is_exc_q;
   assign io.STICKY_FLAGS    = flags_q;
   assign io.EXCE_COUNT      = count_q;
endmodule

// File: tb/tb_fpu_exception_unit.sv
// tb/tb_fpu_exception_unit.sv - directed self-checking bench for fpu_exception_unit
module tb_fpu_exception_unit;
   logic CLK = 1'b0;
   logic RST;
   int   n_chk = 0;
   int   n_err = 0;

   fpu_exception_unit_if #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) u_if ();
   fpu_exception_unit_if #(.EXP_W(4), .MAN_W(3), .CNT_W(2)) u_if2 ();

   fpu_exception_unit #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) u_dut (
      .CLK (CLK),
      .RST (RST),
      .io  (u_if.slave)
   );

   fpu_exception_unit #(.EXP_W(4), .MAN_W(3), .CNT_W(2)) u_dut2 (
      .CLK (CLK),
      .RST (RST),
      .io  (u_if2.slave)
   );

   // the narrow-counter instance sees the same stimulus
   assign u_if2.IN_VALID     = u_if.IN_VALID;
   assign u_if2.FP_OPERATION = u_if.FP_OPERATION;
   assign u_if2.OP_A         = u_if.OP_A;
   assign u_if2.OP_B         = u_if.OP_B;
   assign u_if2.OUT_READY    = u_if.OUT_READY;
   assign u_if2.STICKY_CLR   = u_if.STICKY_CLR;

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      u_if.FP_OPERATION = op;
      u_if.OP_A         = a;
      u_if.OP_B         = b;
      u_if.IN_VALID     = 1'b1;
      @(posedge CLK);
      #1;
      u_if.IN_VALID     = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] exce, input logic [3:0] flags,
                             input logic [7:0] cnt);
      chk({tag, ".valid"}, 32'(u_if.OUT_VALID), 32'd1);
      chk({tag, ".exce"}, 32'(u_if.FP_EXCE), 32'(exce));
      chk({tag, ".is_exc"}, 32'(u_if.OP_IS_EXCEPTION), 32'(exce != 3'b000));
      chk({tag, ".flags"}, 32'(u_if.STICKY_FLAGS), 32'(flags));
      chk({tag, ".count"}, 32'(u_if.EXCE_COUNT), 32'(cnt));
   endtask

   initial begin
      RST               = 1'b1;
      u_if.IN_VALID     = 1'b0;
      u_if.FP_OPERATION = 2'b00;
      u_if.OP_A         = 8'h00;
      u_if.OP_B         = 8'h00;
      u_if.OUT_READY    = 1'b1;
      u_if.STICKY_CLR   = 1'b0;
      @(posedge CLK);
      #1;
      chk("rst.valid", 32'(u_if.OUT_VALID), 32'd0);
      chk("rst.exce", 32'(u_if.FP_EXCE), 32'd0);
      chk("rst.is_exc", 32'(u_if.OP_IS_EXCEPTION), 32'd0);
      chk("rst.flags", 32'(u_if.STICKY_FLAGS), 32'd0);
      chk("rst.count", 32'(u_if.EXCE_COUNT), 32'd0);
      #2;
      RST = 1'b0;
      chk("rst.in_ready", 32'(u_if.IN_READY), 32'd1);
      @(posedge CLK);
      #1;

      // back-to-back stream with OUT_READY=1
      do_op(2'b00, 8'h78, 8'hF8);
      expect_out("add_inf", 3'b010, 4'b0001, 8'd1);
      chk("add_inf.cnt2", 32'(u_if2.EXCE_COUNT), 32'd1);
      do_op(2'b01, 8'hF8, 8'hF8);
      expect_out("sub_ninf", 3'b010, 4'b0001, 8'd2);
      chk("sub_ninf.cnt2", 32'(u_if2.EXCE_COUNT), 32'd2);
      do_op(2'b01, 8'hF8, 8'h78);
      expect_out("sub_ok", 3'b000, 4'b0001, 8'd2);
      do_op(2'b00, 8'h79, 8'h7C);
      expect_out("snan", 3'b100, 4'b1001, 8'd3);
      chk("snan.cnt2", 32'(u_if2.EXCE_COUNT), 32'd3);
      do_op(2'b11, 8'h38, 8'h00);
      expect_out("div_zero", 3'b011, 4'b1011, 8'd4);
      chk("div_zero.cnt2_sat", 32'(u_if2.EXCE_COUNT), 32'd3);
      do_op(2'b11, 8'h00, 8'h80);
      expect_out("div_00", 3'b010, 4'b1011, 8'd5);
      do_op(2'b11, 8'h78, 8'h00);
      expect_out("div_inf0", 3'b000, 4'b1011, 8'd5);
      do_op(2'b10, 8'h80, 8'hF8);
      expect_out("mul_0inf", 3'b010, 4'b1011, 8'd6);
      do_op(2'b10, 8'h7C, 8'h00);
      expect_out("qnan", 3'b001, 4'b1111, 8'd7);
      chk("qnan.cnt2", 32'(u_if2.EXCE_COUNT), 32'd3);

      // drain
      @(posedge CLK);
      #1;
      chk("drain.valid", 32'(u_if.OUT_VALID), 32'd0);

      // backpressure
      u_if.OUT_READY = 1'b0;
      do_op(2'b11, 8'h38, 8'h00);
      expect_out("bp_load", 3'b011, 4'b1111, 8'd8);
      for (int i = 0; i < 3; i++) begin
         u_if.FP_OPERATION = 2'(i);
         u_if.OP_A         = 8'h78;
         u_if.OP_B         = (i == 1) ? 8'h78 : 8'hF8;
         u_if.IN_VALID     = 1'b1;
         #1;
         chk("bp.in_ready", 32'(u_if.IN_READY), 32'd0);
         @(posedge CLK);
         #1;
         expect_out("bp_hold", 3'b011, 4'b1111, 8'd8);
      end
      u_if.OUT_READY = 1'b1;
      #1;
      chk("bp_rel.in_ready", 32'(u_if.IN_READY), 32'd1);
      do_op(2'b00, 8'h78, 8'hF8);
      expect_out("bp_rel", 3'b010, 4'b1111, 8'd9);

      // sticky clear alone while a result is held
      u_if.OUT_READY  = 1'b0;
      u_if.STICKY_CLR = 1'b1;
      @(posedge CLK);
      #1;
      u_if.STICKY_CLR = 1'b0;
      expect_out("clr_alone", 3'b010, 4'b0000, 8'd0);
      chk("clr_alone.cnt2", 32'(u_if2.EXCE_COUNT), 32'd0);

      // five exceptions after clear: narrow counter saturates at 3
      u_if.OUT_READY = 1'b1;
      do_op(2'b00, 8'h78, 8'hF8);
      do_op(2'b00, 8'h79, 8'h7C);
      do_op(2'b00, 8'h78, 8'hF8);
      chk("sat3.cnt2", 32'(u_if2.EXCE_COUNT), 32'd3);
      do_op(2'b11, 8'h38, 8'h00);
      do_op(2'b00, 8'h78, 8'hF8);
      expect_out("five_exc", 3'b010, 4'b1011, 8'd5);
      chk("sat5.cnt2", 32'(u_if2.EXCE_COUNT), 32'd3);

      // clear coinciding with a divide-by-zero accept
      u_if.STICKY_CLR = 1'b1;
      do_op(2'b11, 8'h38, 8'h00);
      u_if.STICKY_CLR = 1'b0;
      expect_out("clr_dbz", 3'b011, 4'b0010, 8'd1);
      chk("clr_dbz.cnt2", 32'(u_if2.EXCE_COUNT), 32'd1);
      chk("clr_dbz.flags2", 32'(u_if2.STICKY_FLAGS), 32'b0010);

      // asynchronous reset between edges while a result is pending
      u_if.OUT_READY = 1'b0;
      #3;
      RST = 1'b1;
      #1;
      chk("arst.valid", 32'(u_if.OUT_VALID), 32'd0);
      chk("arst.exce", 32'(u_if.FP_EXCE), 32'd0);
      chk("arst.is_exc", 32'(u_if.OP_IS_EXCEPTION), 32'd0);
      chk("arst.flags", 32'(u_if.STICKY_FLAGS), 32'd0);
      chk("arst.count", 32'(u_if.EXCE_COUNT), 32'd0);
      chk("arst.in_ready", 32'(u_if.IN_READY), 32'd1);
      chk("arst.cnt2", 32'(u_if2.EXCE_COUNT), 32'd0);
      #1;
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("post_rst.valid", 32'(u_if.OUT_VALID), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fpu_exception_unit.md
# fpu_exception_unit

Parametrised, registered successor of the FPU combinational exception checker. Classifies both operands of an FP operation, detects IEEE-style exceptions (signalling/quiet NaN, invalid operation, divide-by-zero), and delivers the result through a one-deep valid/ready output register. It sits between the FPU issue stage and the arithmetic datapath. It keeps sticky exception flags and a saturating exception counter for status readback.

## Interface
- EXP_W, 4: exponent field width.
- MAN_W, 3: mantissa field width; W = 1+EXP_W+MAN_W (8 by default), sign is MSB.
- CNT_W, 8: exception counter width.

- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- IN_VALID  in  1  operation request valid.
- IN_READY  out  1  unit can accept a request.
- FP_OPERATION  in  2  00 add, 01 sub, 10 mul, 11 div.
- OP_A, OP_B  in  W  operands.
- OUT_VALID  out  1  registered result valid.
- OUT_READY  in  1  downstream accepts result.
- OP_IS_EXCEPTION  out  1  registered: FP_EXCE != 000.
- FP_EXCE  out  3  000 none, 001 qNaN, 010 invalid (INF_EXCE), 011 divide-by-zero, 100 sNaN.
- STICKY_FLAGS  out  4  [0] invalid, [1] div-by-zero, [2] qNaN, [3] sNaN.
- STICKY_CLR  in  1  synchronous clear of STICKY_FLAGS and EXCE_COUNT.
- EXCE_COUNT  out  CNT_W  number of accepted results with an exception, saturating.

## Operation
- Classification per operand: NaN = exp all ones and mantissa != 0; quiet if mantissa MSB = 1, otherwise signalling. Inf = exp all ones and mantissa 0. Zero = exp 0 and mantissa 0, either sign.
- Priority, highest first: sNaN on either operand -> 100; qNaN on either operand -> 001; invalid -> 010; divide-by-zero -> 011; else 000.
- Invalid conditions:
  - add: both inf with opposite signs.
  - sub: both inf with equal signs; covers both +inf-(+inf) and -inf-(-inf).
  - mul: zero x inf, either order.
  - div: 0/0 or inf/inf.
- Divide-by-zero: div with B zero and A finite nonzero. inf/0 raises no exception.
- Request accepted when IN_VALID && IN_READY. IN_READY = !OUT_VALID || OUT_READY (combinational).
- On accept, the output register loads FP_EXCE and OP_IS_EXCEPTION and OUT_VALID is set.
- If OUT_VALID && OUT_READY with no accept on the same edge, OUT_VALID clears. The output register holds its value while OUT_VALID && !OUT_READY.
- Sticky flags and counter update only on accept:
  - sNaN sets [3] and [0].
  - qNaN sets [2].
  - invalid sets [0].
  - div-by-zero sets [1].
  - Counter +1 if the code is nonzero; it holds at 2^CNT_W-1.
- STICKY_CLR on the same edge as an accept with an exception: the clear applies first, then the new event. Flags = the new event's bits; counter = 1.

## Timing
- Reset (async assert, sync release): OUT_VALID=0, FP_EXCE=000, OP_IS_EXCEPTION=0, STICKY_FLAGS=0000, EXCE_COUNT=0. IN_READY=1 after reset.
- Latency: 1 cycle from accept to OUT_VALID.
- Throughput: 1 per cycle while OUT_READY=1.
- Back-to-back: accept on edge N while result N-1 drains replaces the register, with no bubble.
- Backpressure: OUT_READY=0 with OUT_VALID=1 forces IN_READY=0. Inputs are ignored, and the flags and counter do not change.
- Reset mid-stream: the pending result is discarded, and flags and counter are cleared immediately (async).
- STICKY_CLR alone: flags and counter are 0 on the next cycle. It does not affect OUT_VALID or FP_EXCE.

## Test plan
- Reset, then add 0x78 + 0xF8 (+inf + -inf), OUT_READY=1 -> next cycle OUT_VALID=1, FP_EXCE=010, OP_IS_EXCEPTION=1, STICKY_FLAGS=0001, EXCE_COUNT=1.
- sub 0xF8 - 0xF8 -> 010. sub 0xF8 - 0x78 -> 000. add 0x79 + 0x7C (sNaN + qNaN) -> 100, flags [3] and [0] set.
- div 0x38/0x00 -> 011. div 0x00/0x80 -> 010. div 0x78/0x00 -> 000. mul 0x80 x 0xF8 -> 010.
- Hold OUT_READY=0 for 3 cycles with IN_VALID=1 and changing operands -> IN_READY=0; output, flags and count are frozen. Release OUT_READY -> the next operand is accepted the same edge.
- CNT_W=2: stream 5 exception ops -> EXCE_COUNT saturates at 3. STICKY_CLR coinciding with a div-by-zero accept -> flags=0010, count=1.
- Assert RST asynchronously mid-cycle with OUT_VALID=1 -> all outputs reach their reset values immediately, before the next CLK edge.
